// File: rtl/mem_lsu_if.sv
// Request/response and memory-port bundle between the execute stage, mem_lsu and the word memory.
interface mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_dataIn;
   logic        mem_wEn;
   logic [31:0] mem_memOut;

   // LSU side
   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_memOut,
      output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_dataIn, mem_wEn
   );

   // Requester / memory side
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_memOut,
      input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_dataIn, mem_wEn
   );
endinterface

// File: rtl/mem_lsu.sv
// RV32I load/store unit in front of a single-port word memory without byte enables; SB/SH use read-modify-write.
// Optional macro MEM_LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned.
module mem_lsu #(
   parameter int unsigned WORD_IDX_W = 5
) (
   input  logic      clk,
   input  logic      rst,
   mem_lsu_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_write;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lane_addr;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_din;
   logic [31:0] r_rdata;
   logic        r_fault;

   logic        w_size_b;
   logic        w_size_h;
   logic        w_size_w;
   logic        w_illegal;
   logic        w_fault;
   logic [1:0]  w_lane;
   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;
   logic [31:0] w_load;
   logic [31:0] w_mask;
   logic [31:0] w_merged;
   logic        w_rmw;
   logic        w_sw;
   logic [31:0] w_req_idx;
   logic        w_req_ready;
   logic        w_resp_valid;
   logic        w_wen;
   logic        w_unused_addr;

   assign w_req_idx     = 32'(bus.req_addr[WORD_IDX_W+1:2]);
   assign w_unused_addr = ^bus.req_addr;

   // Access decode from the captured request
   assign w_size_b  = (r_funct3[1:0] == 2'b00);
   assign w_size_h  = (r_funct3[1:0] == 2'b01);
   assign w_size_w  = (r_funct3[1:0] == 2'b10);
   assign w_illegal = r_write ? (r_funct3[2] | (r_funct3[1:0] == 2'b11))
                              : ((r_funct3[1:0] == 2'b11) | (r_funct3[2:1] == 2'b11));

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   logic w_misalign;
   assign w_misalign = (w_size_h & r_lane_addr[0]) | (w_size_w & (|r_lane_addr));
   assign w_fault    = w_illegal | w_misalign;
   assign w_lane     = r_lane_addr;
`else
   assign w_fault    = w_illegal;
   assign w_lane     = w_size_w ? 2'b00 :
                       w_size_h ? {r_lane_addr[1], 1'b0} : r_lane_addr;
`endif

   assign w_sw  = r_write & w_size_w & ~w_fault;
   assign w_rmw = r_write & ~w_size_w & ~w_fault;

   // Lane extraction and extension for loads
   assign w_shamt   = {w_lane, 3'b000};
   assign w_shifted = bus.mem_memOut >> w_shamt;

   always_comb begin
      w_load = 32'd0;
      unique case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_load = bus.mem_memOut;
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = 32'd0;
      endcase
   end

   // Byte/halfword merge into the word read back from memory
   assign w_mask   = (w_size_b ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
   assign w_merged = (bus.mem_memOut & ~w_mask) | ((r_mem_din << w_shamt) & w_mask);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      w_wen        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            w_wen  = w_sw;
            w_next = w_rmw ? S_WRITE : S_RESP;
         end
         S_WRITE: begin
            w_wen  = 1'b1;
            w_next = S_RESP;
         end
         S_RESP: begin
            w_resp_valid = 1'b1;
            w_next       = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, response and memory-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_write     <= 1'b0;
         r_funct3    <= 3'd0;
         r_lane_addr <= 2'd0;
         r_mem_addr  <= 32'd0;
         r_mem_din   <= 32'd0;
         r_rdata     <= 32'd0;
         r_fault     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_write     <= bus.req_write;
                  r_funct3    <= bus.req_funct3;
                  r_lane_addr <= bus.req_addr[1:0];
                  r_mem_addr  <= w_req_idx;
                  r_mem_din   <= bus.req_wdata;
                  r_rdata     <= 32'd0;
                  r_fault     <= 1'b0;
               end
            end
            S_ACCESS: begin
               r_fault <= w_fault;
               r_rdata <= (!w_fault && !r_write) ? w_load : 32'd0;
               if (w_rmw) r_mem_din <= w_merged;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_fault = r_fault;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_dataIn = r_mem_din;
   assign bus.mem_wEn    = w_wen & ~rst;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: byte-array reference model, per-cycle compare process, directed vectors.
module tb_mem_lsu;

   logic clk = 1'b0;
   logic rst;
   mem_lsu_if bus ();

   mem_lsu #(.WORD_IDX_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0] dmem [32];
   assign bus.mem_memOut = dmem[bus.mem_addr[4:0]];
   always @(posedge clk) if (bus.mem_wEn) dmem[bus.mem_addr[4:0]] <= bus.mem_dataIn;

   logic [7:0]  ref_b [128];
   int          checks = 0;
   int          failures = 0;
   logic        chk_en = 1'b0;
   logic        pending = 1'b0;
   int          cnt = 0;
   logic [31:0] exp_rdata;
   logic        exp_fault;
   int          exp_lat;
   int          exp_wen_cyc;
   logic [31:0] exp_idx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mword(input logic [31:0] idx);
      int b;
      b = int'(idx[4:0]) * 4;
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   // Reference: byte-addressed little-endian memory with RV32I access rules
   task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int          size;
      logic        legal;
      logic        mis;
      int          ba;
      logic [31:0] v;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = w ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis   = (int'(a[1:0]) % size) != 0;
      ba    = int'(a[6:0]);
      exp_fault = !legal;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      exp_fault = exp_fault | mis;
`else
      if (mis) ba = ba - (int'(a[1:0]) % size);
`endif
      exp_idx     = 32'(a[6:2]);
      exp_rdata   = 32'd0;
      exp_lat     = 2;
      exp_wen_cyc = 0;
      if (!exp_fault) begin
         if (w) begin
            for (int i = 0; i < size; i++) ref_b[ba+i] = wd[8*i +: 8];
            exp_lat     = (size == 4) ? 2 : 3;
            exp_wen_cyc = (size == 4) ? 1 : 2;
         end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_b[ba+i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            exp_rdata = v;
         end
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      @(negedge clk);
      while ((pending || !bus.req_ready) && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         chk("ready_timeout", {31'd0, pending}, 32'd0);
         pending = 1'b0;
      end
   endtask

   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      wait_ready();
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      model(w, f3, a, wd);
      cnt     = 0;
      pending = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (pending && k < 20) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Per-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         if (pending) begin
            cnt++;
            chk("busy_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("mem_addr", bus.mem_addr, exp_idx);
            chk("mem_wEn", {31'd0, bus.mem_wEn}, {31'd0, (cnt == exp_wen_cyc)});
            if (bus.mem_wEn) chk("mem_dataIn", bus.mem_dataIn, mword(exp_idx));
            chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, (cnt == exp_lat)});
            if (bus.resp_valid) begin
               chk("resp_rdata", bus.resp_rdata, exp_rdata);
               chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, exp_fault});
               chk("mem_word", dmem[exp_idx[4:0]], mword(exp_idx));
               pending = 1'b0;
            end else if (cnt >= exp_lat) begin
               chk("resp_timeout", 32'(cnt), 32'(exp_lat));
               pending = 1'b0;
            end
         end else begin
            chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("idle_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
            chk("idle_wEn", {31'd0, bus.mem_wEn}, 32'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] pre;
      for (int i = 0; i < 32; i++) dmem[i] = 32'd0;
      for (int i = 0; i < 128; i++) ref_b[i] = 8'd0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wEn", {31'd0, bus.mem_wEn}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
      chk("rst_fault", {31'd0, bus.resp_fault}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_dataIn", bus.mem_dataIn, 32'd0);
      chk_en = 1'b1;

      // SW then LW of word 2
      issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF); wait_done();
      chk("sw_word2", dmem[2], 32'hDEAD_BEEF);
      issue(1'b0, 3'b010, 32'h8, 32'h0);
      chk("lw_model", exp_rdata, 32'hDEAD_BEEF); wait_done();

      // SB read-modify-write
      issue(1'b1, 3'b000, 32'h9, 32'h0000_0055); wait_done();
      chk("sb_word2", dmem[2], 32'hDEAD_55EF);

      // Lane selection and extension
      issue(1'b0, 3'b000, 32'hB, 32'h0); chk("lb_model",  exp_rdata, 32'hFFFF_FFDE);
      issue(1'b0, 3'b100, 32'hB, 32'h0); chk("lbu_model", exp_rdata, 32'h0000_00DE);
      issue(1'b0, 3'b001, 32'hA, 32'h0); chk("lh_model",  exp_rdata, 32'hFFFF_DEAD);
      issue(1'b0, 3'b101, 32'h8, 32'h0); chk("lhu_model", exp_rdata, 32'h0000_55EF);

      // Illegal store funct3 leaves memory alone
      issue(1'b1, 3'b010, 32'h4, 32'hCAFE_F00D);
      issue(1'b1, 3'b011, 32'h4, 32'h1111_1111);
      chk("ill_st_fault_model", {31'd0, exp_fault}, 32'd1);
      wait_done();
      chk("ill_st_word1", dmem[1], 32'hCAFE_F00D);

      // Misaligned halfword
      issue(1'b0, 3'b001, 32'h5, 32'h0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      chk("lh5_fault_model", {31'd0, exp_fault}, 32'd1);
`else
      chk("lh5_model", exp_rdata, 32'hFFFF_F00D);
`endif

      // Further patterns: SH, misaligned W, illegal loads/stores, sign bit, aliasing, top word
      issue(1'b1, 3'b001, 32'h6, 32'h0000_A5A5); wait_done();
      chk("sh_word1", dmem[1], 32'hA5A5_F00D);
      issue(1'b0, 3'b010, 32'h7, 32'h0);
      issue(1'b0, 3'b101, 32'h6, 32'h0);
      issue(1'b0, 3'b110, 32'h4, 32'h0);
      issue(1'b0, 3'b111, 32'h4, 32'h0);
      issue(1'b0, 3'b011, 32'h4, 32'h0);
      issue(1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF);
      issue(1'b1, 3'b000, 32'h7, 32'h0000_0080);
      issue(1'b0, 3'b000, 32'h7, 32'h0); chk("lb_neg_model", exp_rdata, 32'hFFFF_FF80);
      issue(1'b1, 3'b001, 32'h1, 32'h0000_BEEF);
      issue(1'b1, 3'b010, 32'h7C, 32'h0BAD_CAFE);
      issue(1'b0, 3'b010, 32'h17C, 32'h0);
      issue(1'b0, 3'b100, 32'h7E, 32'h0);
      issue(1'b1, 3'b010, 32'h0, 32'h1122_3344);
      wait_done();

      // Reset during the WRITE cycle of an SH
      wait_ready();
      chk_en = 1'b0;
      pre = dmem[0];
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0000_1234;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_wEn", {31'd0, bus.mem_wEn}, 32'd1);
      chk("rmw_dataIn", bus.mem_dataIn, 32'h1122_1234);
      rst = 1'b1;
      #1;
      chk("rst_gate_wEn", {31'd0, bus.mem_wEn}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("abort_resp", {31'd0, bus.resp_valid}, 32'd0);
      chk("abort_word0", dmem[0], pre);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      end
      chk_en = 1'b1;

      // Normal operation after the abort
      issue(1'b0, 3'b010, 32'h0, 32'h0); chk("post_abort_model", exp_rdata, 32'h1122_3344);
      wait_done();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
